// File: rtl/strip_allocator.sv
// strip_allocator: places one program per job into the first of up to three
// candidate strips that still has horizontal room, tracking per-strip column
// occupancy. One candidate is examined per cycle; a result is held until the
// downstream side accepts it.
// Optional build macro: ALLOC_STATS_EN adds saturating placed/failed counters.
module strip_allocator #(
    parameter int STRIP_WIDTH = 128,
    parameter int NUM_STRIPS  = 13,
    parameter int X_W         = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [4:0]     prog_width_i,
    input  logic [3:0]     cand_0_i,
    input  logic [3:0]     cand_1_i,
    input  logic [3:0]     cand_2_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [3:0]     strip_id_o,
    output logic [X_W-1:0] x_o,
    output logic           fail_o
`ifdef ALLOC_STATS_EN
    ,
    output logic [15:0]    placed_cnt_o,
    output logic [15:0]    fail_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRY  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic           r_in_ready;
    logic [4:0]     r_width;
    logic [3:0]     r_cand0, r_cand1, r_cand2;
    logic [1:0]     r_idx;
    logic           r_out_valid;
    logic [3:0]     r_strip_id;
    logic [X_W-1:0] r_x;
    logic           r_fail;
    logic [X_W-1:0] r_used [1:NUM_STRIPS];

    logic [3:0]     w_cand;
    logic           w_id_ok;
    logic [X_W-1:0] w_used_c;
    logic [X_W:0]   w_sum;
    logic           w_fit;
    logic           w_accept;
    logic           w_place;
    logic           w_out_hs;

    // Select the candidate under examination for this TRY cycle
    always_comb begin
        case (r_idx)
            2'd0:    w_cand = r_cand0;
            2'd1:    w_cand = r_cand1;
            default: w_cand = r_cand2;
        endcase
    end

    // Read the occupancy of the current candidate; out-of-range IDs read 0
    always_comb begin
        w_used_c = '0;
        for (int i = 1; i <= NUM_STRIPS; i++) begin
            if (w_cand == 4'(i)) w_used_c = r_used[i];
        end
    end

    // Fit test is one bit wider than the occupancy so the sum cannot wrap
    assign w_id_ok  = (w_cand != 4'd0) && (w_cand <= 4'(NUM_STRIPS));
    assign w_sum    = {1'b0, w_used_c} + (X_W+1)'(r_width);
    assign w_fit    = w_id_ok && (w_sum <= (X_W+1)'(STRIP_WIDTH));
    assign w_accept = in_valid_i && r_in_ready && (r_state == S_IDLE);
    assign w_place  = (r_state == S_TRY) && w_fit;
    assign w_out_hs = r_out_valid && out_ready_i;

    // Job control: accept, walk candidates, hold result until handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_width     <= '0;
            r_cand0     <= '0;
            r_cand1     <= '0;
            r_cand2     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_strip_id  <= '0;
            r_x         <= '0;
            r_fail      <= 1'b0;
        end else if (clear_i) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_strip_id  <= '0;
            r_x         <= '0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= !w_accept;
                    if (w_accept) begin
                        r_width <= prog_width_i;
                        r_cand0 <= cand_0_i;
                        r_cand1 <= cand_1_i;
                        r_cand2 <= cand_2_i;
                        r_idx   <= 2'd0;
                        r_state <= S_TRY;
                    end
                end
                S_TRY: begin
                    if (w_fit) begin
                        r_x         <= w_used_c;
                        r_strip_id  <= w_cand;
                        r_fail      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_idx == 2'd2) begin
                        r_x         <= '0;
                        r_strip_id  <= '0;
                        r_fail      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_RESP: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy: bump the chosen strip by the program width on a placement
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i <= NUM_STRIPS; i++) r_used[i] <= '0;
        end else if (clear_i) begin
            for (int i = 1; i <= NUM_STRIPS; i++) r_used[i] <= '0;
        end else if (w_place) begin
            for (int i = 1; i <= NUM_STRIPS; i++) begin
                if (w_cand == 4'(i)) r_used[i] <= w_sum[X_W-1:0];
            end
        end
    end

`ifdef ALLOC_STATS_EN
    logic [15:0] r_placed_cnt;
    logic [15:0] r_fail_cnt;

    // Saturating result counters, stepped when a result is handed off
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_placed_cnt <= '0;
            r_fail_cnt   <= '0;
        end else if (clear_i) begin
            r_placed_cnt <= '0;
            r_fail_cnt   <= '0;
        end else if (w_out_hs) begin
            if (r_fail) begin
                if (r_fail_cnt != 16'hFFFF) r_fail_cnt <= r_fail_cnt + 16'd1;
            end else begin
                if (r_placed_cnt != 16'hFFFF) r_placed_cnt <= r_placed_cnt + 16'd1;
            end
        end
    end

    assign placed_cnt_o = r_placed_cnt;
    assign fail_cnt_o   = r_fail_cnt;
`else
    // Handshake only matters to the counters; keep it referenced
    logic w_unused_hs;
    assign w_unused_hs = w_out_hs;
`endif

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign strip_id_o  = r_strip_id;
    assign x_o         = r_x;
    assign fail_o      = r_fail;

endmodule

// File: tb/tb_strip_allocator.sv
`timescale 1ns/1ps
module tb_strip_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] prog_width = '0;
    logic [3:0] c0 = '0, c1 = '0, c2 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] strip_id;
    logic [7:0] x;
    logic       fail;
`ifdef ALLOC_STATS_EN
    logic [15:0] placed_cnt, fail_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    strip_allocator dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .prog_width_i(prog_width),
        .cand_0_i(c0), .cand_1_i(c1), .cand_2_i(c2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .strip_id_o(strip_id), .x_o(x), .fail_o(fail)
`ifdef ALLOC_STATS_EN
        , .placed_cnt_o(placed_cnt), .fail_cnt_o(fail_cnt)
`endif
    );

    task automatic chk(input string tag, input bit ok, input longint obs, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic job(input int w, input int a, input int b, input int c,
                       input int exp_id, input int exp_x, input int exp_fail,
                       input int exp_lat, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, in_ready === 1'b1, in_ready, 1);
        prog_width = 5'(w); c0 = 4'(a); c1 = 4'(b); c2 = 4'(c);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin @(negedge clk); n++; end
        chk({tag, "_lat"}, n === exp_lat, n, exp_lat);
        chk({tag, "_id"}, strip_id === 4'(exp_id), strip_id, exp_id);
        chk({tag, "_x"}, x === 8'(exp_x), x, exp_x);
        chk({tag, "_fail"}, fail === 1'(exp_fail), fail, exp_fail);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop"}, out_valid === 1'b0, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int n;
        #12;
        chk("rst_ready", in_ready === 1'b0, in_ready, 0);
        chk("rst_valid", out_valid === 1'b0, out_valid, 0);
        chk("rst_id", strip_id === 4'd0, strip_id, 0);
        chk("rst_x", x === 8'd0, x, 0);
        chk("rst_fail", fail === 1'b0, fail, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", in_ready === 1'b1, in_ready, 1);

        for (int j = 0; j < 8; j++) job(16, 13, 12, 11, 13, 16*j, 0, 2, "s13");
        job(16, 13, 12, 11, 12, 0, 0, 3, "spill12");

        job(5, 0, 0, 0, 0, 0, 1, 4, "empty");
        job(16, 12, 0, 0, 12, 16, 0, 2, "s12_unch");

        job(4, 15, 0, 5, 5, 0, 0, 4, "skip");

        for (int j = 0; j < 18; j++) job(7, 4, 0, 0, 4, 7*j, 0, 2, "s4");
        job(7, 4, 0, 0, 0, 0, 1, 4, "s4_over");
        job(2, 4, 0, 0, 4, 126, 0, 2, "s4_exact");
        job(4, 4, 4, 4, 0, 0, 1, 4, "s4_full");

        out_ready = 1'b0;
        prog_width = 5'd4; c0 = 4'd5; c1 = 4'd0; c2 = 4'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = 4'd6;
        n = 1;
        while (!out_valid && n < 12) begin @(negedge clk); n++; end
        chk("stall_lat", n === 2, n, 2);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", out_valid === 1'b1, out_valid, 1);
            chk("stall_id", strip_id === 4'd5, strip_id, 5);
            chk("stall_x", x === 8'd4, x, 4);
            chk("stall_rdy", in_ready === 1'b0, in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_drop", out_valid === 1'b0, out_valid, 0);
        job(4, 6, 0, 0, 6, 0, 0, 2, "s6_fresh");

        prog_width = 5'd16; c0 = 4'd15; c1 = 4'd15; c2 = 4'd13;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
`ifdef ALLOC_STATS_EN
        chk("clr_placed", placed_cnt === 16'd0, placed_cnt, 0);
        chk("clr_failcnt", fail_cnt === 16'd0, fail_cnt, 0);
`endif
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("clr_noresp", seen === 1'b0, seen, 0);
        chk("clr_rdy", in_ready === 1'b1, in_ready, 1);

        prog_width = 5'd16; c0 = 4'd13; c1 = 4'd0; c2 = 4'd0;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("clr_in_ignored", seen === 1'b0, seen, 0);

        job(16, 13, 12, 11, 13, 0, 0, 2, "post_clr13");
        job(7, 4, 0, 0, 4, 0, 0, 2, "post_clr4");
        job(16, 0, 0, 0, 0, 0, 1, 4, "post_clr_fail");
`ifdef ALLOC_STATS_EN
        chk("cnt_placed", placed_cnt === 16'd2, placed_cnt, 2);
        chk("cnt_fail", fail_cnt === 16'd1, fail_cnt, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
